// File: rtl/psum_ofifo_pkg.sv
// Shared constants and lane-slicing helper for the psum output FIFO,
// the column array and the downstream row reader.
package psum_ofifo_pkg;

    localparam int COL        = 8;
    localparam int BW_PSUM    = 19;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    // Lowest bit of lane idx inside a packed row of bw-bit lanes;
    // the lane occupies [lane_lsb(idx,bw) +: bw].
    function automatic int lane_lsb(input int idx, input int bw);
        return idx * bw;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// Single-lane synchronous FIFO with wrap-bit pointers.
// Head data is presented combinationally; a push into a full lane is
// only taken when the same edge also pops.
module fifo_lane #(
    parameter int depth = 16,
    parameter int ptr_w = 4,
    parameter int bw    = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [bw-1:0] din,
    input  logic          rd_en,
    output logic [bw-1:0] dout,
    output logic          empty,
    output logic          full
);

    logic [bw-1:0]  r_mem [depth];
    logic [ptr_w:0] r_wptr;
    logic [ptr_w:0] r_rptr;
    logic           w_push;
    logic           w_pop;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[ptr_w-1:0] == r_rptr[ptr_w-1:0])
                  & (r_wptr[ptr_w] != r_rptr[ptr_w]);
    assign w_pop  = rd_en & ~empty;
    assign w_push = wr_en & (~full | w_pop);
    assign dout   = r_mem[r_rptr[ptr_w-1:0]];

    // Pointer advance; the MSB acts as the wrap flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[ptr_w-1:0]] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Per-column psum FIFOs that realign skewed column writes into rows.
// A row pops only when every lane holds data; flags are sticky.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = FIFO_DEPTH,
    parameter int ptr_w   = FIFO_PTR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*bw_psum-1:0] in,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_out_valid,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [col-1:0]         w_empty;
    logic [col-1:0]         w_full;
    logic [col*bw_psum-1:0] w_head;
    logic                   w_pop;
    logic                   w_drop;

    assign o_valid = &(~w_empty);
    assign o_full  = |w_full;
    assign w_pop   = rd & o_valid;
    assign w_drop  = |(wr & w_full & ~{col{w_pop}});

    for (genvar i = 0; i < col; i++) begin : g_lane
        fifo_lane #(
            .depth (depth),
            .ptr_w (ptr_w),
            .bw    (bw_psum)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr[i]),
            .din   (in[lane_lsb(i, bw_psum) +: bw_psum]),
            .rd_en (w_pop),
            .dout  (w_head[lane_lsb(i, bw_psum) +: bw_psum]),
            .empty (w_empty[i]),
            .full  (w_full[i])
        );
    end

    // Row capture on pop, one-cycle valid pulse, sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            o_out_valid <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_out_valid <= w_pop;
            if (w_pop)          out         <= w_head;
            if (w_drop)         o_overflow  <= 1'b1;
            if (rd & ~o_valid)  o_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomised and directed bench for psum_ofifo against a per-lane
// queue model of the row FIFO.
module tb_psum_ofifo;

    localparam int C  = 8;
    localparam int BW = 19;
    localparam int D  = 16;
    localparam int RW = C * BW;

    logic          clk;
    logic          t_reset;
    logic [C-1:0]  t_wr;
    logic [RW-1:0] t_in;
    logic          t_rd;
    logic [RW-1:0] out;
    logic          o_valid, o_out_valid, o_full;
    logic          o_overflow, o_underflow;

    int n_vec = 0;
    int n_mis = 0;

    logic [BW-1:0] mq [C][$];
    logic [RW-1:0] m_out;
    logic          m_outv, m_ovf, m_unf;

    psum_ofifo dut (
        .clk         (clk),
        .reset       (t_reset),
        .wr          (t_wr),
        .in          (t_in),
        .rd          (t_rd),
        .out         (out),
        .o_valid     (o_valid),
        .o_out_valid (o_out_valid),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pack(input int base, input int mul);
        logic [RW-1:0] v;
        v = '0;
        for (int i = 0; i < C; i++) v[i*BW +: BW] = BW'(base + mul * i);
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [RW-1:0] a,
                       input logic [RW-1:0] e);
        n_vec++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic model_update(input logic [C-1:0] w, input logic [RW-1:0] d,
                                input logic r, input logic rs);
        bit v;
        bit pop;
        bit fl [C];
        if (rs) begin
            for (int i = 0; i < C; i++) mq[i].delete();
            m_out  = '0;
            m_outv = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        v = 1'b1;
        for (int i = 0; i < C; i++) begin
            if (mq[i].size() == 0) v = 1'b0;
            fl[i] = (mq[i].size() == D);
        end
        pop = r & v;
        m_outv = pop;
        if (pop)
            for (int i = 0; i < C; i++) m_out[i*BW +: BW] = mq[i].pop_front();
        if (r && !v) m_unf = 1'b1;
        for (int i = 0; i < C; i++)
            if (w[i]) begin
                if (!fl[i] || pop) mq[i].push_back(d[i*BW +: BW]);
                else m_ovf = 1'b1;
            end
    endtask

    task automatic check_all();
        bit ev;
        bit ef;
        ev = 1'b1;
        ef = 1'b0;
        for (int i = 0; i < C; i++) begin
            if (mq[i].size() == 0) ev = 1'b0;
            if (mq[i].size() == D) ef = 1'b1;
        end
        cmp("o_valid", RW'(o_valid), RW'(ev));
        cmp("o_full", RW'(o_full), RW'(ef));
        cmp("o_out_valid", RW'(o_out_valid), RW'(m_outv));
        cmp("o_overflow", RW'(o_overflow), RW'(m_ovf));
        cmp("o_underflow", RW'(o_underflow), RW'(m_unf));
        cmp("out", out, m_out);
    endtask

    task automatic step(input logic [C-1:0] w, input logic [RW-1:0] d,
                        input logic r, input logic rs);
        t_wr    = w;
        t_in    = d;
        t_rd    = r;
        t_reset = rs;
        model_update(w, d, r, rs);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        step('0, '0, 1'b0, 1'b1);
    endtask

    task automatic fill16(input int base);
        for (int r = 0; r < D; r++) step('1, pack(base + r * C, 1), 1'b0, 1'b0);
    endtask

    initial begin
        logic [RW-1:0] d;
        logic [RW-1:0] held;
        int wn;
        int rn;
        bit dw;
        bit dr;

        t_wr = '0; t_in = '0; t_rd = 1'b0; t_reset = 1'b1;
        @(negedge clk);
        do_reset();
        do_reset();
        cmp("reset out", out, '0);
        cmp("reset o_valid", RW'(o_valid), '0);

        for (int i = 0; i < C; i++) begin
            step(C'(1 << i), pack(100, 1), 1'b0, 1'b0);
            cmp("skew o_valid", RW'(o_valid), RW'(i == C - 1));
        end
        step('0, '0, 1'b1, 1'b0);
        cmp("skew o_out_valid", RW'(o_out_valid), RW'(1));
        cmp("skew row", out, pack(100, 1));
        cmp("skew o_valid after", RW'(o_valid), '0);

        wn = 0;
        rn = 0;
        while (rn < 40) begin
            dw = (wn < 40) && (wn - rn < 10) && ($urandom_range(0, 1) == 1);
            dr = (wn - rn > 0) && ($urandom_range(0, 2) == 0);
            step(dw ? '1 : '0, pack(wn * C, 1), dr, 1'b0);
            if (dw) wn++;
            if (dr) rn++;
        end
        cmp("wrap o_overflow", RW'(o_overflow), '0);
        cmp("wrap o_underflow", RW'(o_underflow), '0);

        do_reset();
        fill16(2000);
        cmp("fill o_full", RW'(o_full), RW'(1));
        step(C'(8'h08), pack(5555, 0), 1'b0, 1'b0);
        cmp("drop o_overflow", RW'(o_overflow), RW'(1));
        for (int r = 0; r < D; r++) begin
            step('0, '0, 1'b1, 1'b0);
            cmp("drain row", out, pack(2000 + r * C, 1));
        end

        do_reset();
        fill16(3000);
        step('1, pack(999, 0), 1'b1, 1'b0);
        cmp("popwr row0", out, pack(3000, 1));
        cmp("popwr o_full", RW'(o_full), RW'(1));
        cmp("popwr o_overflow", RW'(o_overflow), '0);
        for (int r = 0; r < D; r++) step('0, '0, 1'b1, 1'b0);
        cmp("popwr 999", out, pack(999, 0));

        do_reset();
        step(C'(8'hdf), pack(50, 1), 1'b0, 1'b0);
        held = out;
        step('0, '0, 1'b1, 1'b0);
        cmp("unf o_out_valid", RW'(o_out_valid), '0);
        cmp("unf o_underflow", RW'(o_underflow), RW'(1));
        cmp("unf out held", out, held);

        do_reset();
        for (int r = 0; r < 3; r++) step('1, pack(r * 11, 1), 1'b0, 1'b0);
        do_reset();
        cmp("rst out", out, '0);
        cmp("rst o_valid", RW'(o_valid), '0);
        cmp("rst o_full", RW'(o_full), '0);
        step('1, pack(0, 7), 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        cmp("rst fresh row", out, pack(0, 7));
        cmp("rst fresh valid", RW'(o_out_valid), RW'(1));

        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < C; i++) d[i*BW +: BW] = BW'($urandom);
            step(C'($urandom_range(0, 255)), d, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output-side collector for the column array. Each column raises its FIFO write strobe and presents a psum, and columns are skewed in time by their pipeline position.
- The block gives every column its own small FIFO, so skewed writes realign into complete rows.
- It presents one full row (one psum per column) to the downstream reader through a valid/read handshake.
- It sits between the column outputs and the SRAM write-back or normalisation stage.

Parameters:
- col, 8, number of columns/lanes
- bw_psum, 19, psum width per lane (2*bw+3 with bw=8)
- depth, 16, entries per lane FIFO; must be a power of two, >=2
- ptr_w, 4, log2(depth)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr  in  col  per-lane write strobe; bit i comes from column i's fifo_wr
- in  in  col*bw_psum  packed psums; lane i occupies [(i+1)*bw_psum-1 : i*bw_psum]
- rd  in  1  row pop request from reader
- out  out  col*bw_psum  registered row data, same packing as in
- o_valid  out  1  a complete row is available (every lane non-empty)
- o_out_valid  out  1  out holds a freshly popped row (one-cycle pulse per pop)
- o_full  out  1  at least one lane is full
- o_overflow  out  1  sticky: a write was dropped on a full lane
- o_underflow  out  1  sticky: rd was asserted while o_valid was 0

Behaviour:
- Reset (synchronous, active-high; clock clk) sets:
  - all read/write pointers to 0
  - out=0, o_out_valid=0, o_overflow=0, o_underflow=0
  - o_valid=0, o_full=0
  - memory contents are don't-care
- Per-lane storage and pointers:
  - each lane has ptr_w+1 bit read and write pointers; the MSB distinguishes wrap
  - empty_i when the pointers are equal
  - full_i when the low bits are equal and the MSBs differ
- Output flags:
  - o_valid = AND over lanes of !empty_i, computed combinationally from registered pointers
  - o_full = OR over lanes of full_i
- Pop:
  - pop = rd & o_valid
  - on pop every lane reads its head and advances its rd pointer in the same cycle
  - out <= heads at that edge, and o_out_valid is 1 in the following cycle only
  - without a pop, out holds its value and o_out_valid=0
  - read latency is 1 cycle from the accepted rd edge to valid out
- Write, per lane:
  - accepted when wr[i] & (!full_i | pop)
  - a full lane accepts a write in the same cycle as a pop; the count is unchanged
  - wr[i] on a full lane without a pop drops the data, leaves the pointers unchanged, and sets o_overflow
- Underflow:
  - rd & !o_valid does nothing to the pointers or out, and sets o_underflow
  - a write into an empty lane in the same cycle as rd does not make that rd succeed, because o_valid reflects pre-edge state
- Wrap-around: pointers wrap naturally modulo 2*depth. Data order is strictly FIFO per lane.
- Lanes are independent:
  - lanes may hold different counts
  - o_valid waits for the slowest lane
  - rows are never mixed across pops
- Sticky flags clear only on reset.
- Reset mid-operation discards all stored rows. The first cycle after reset release behaves as empty.

Decomposition:
- Shared package holds:
  - default constants COL=8, BW_PSUM=19, FIFO_DEPTH=16
  - a lane-slice helper (index to bit range) shared with the column array and the reader
- Sub-module fifo_lane, instantiated col times:
  - single-lane synchronous FIFO (depth, bw_psum)
  - ports: wr_en, din, rd_en, dout, empty, full
  - psum_ofifo holds only the row-valid logic, pop broadcast, output register and flags

Test Plan:
- Skewed fill: wr[i] pulses at cycle 10+i with lane i = 100+i.
  - o_valid stays 0 through cycle 17 and is 1 after the cycle-17 edge.
  - rd=1 pops the row; the next cycle gives o_out_valid=1 and out lanes 100..107.
  - o_valid then returns to 0.
- Order and wrap: write 40 rows (row r, lane i = r*8+i) interleaved with pops, occupancy kept <=10.
  - All 40 rows read back in order, including across the pointer wrap.
  - o_overflow=0, o_underflow=0.
- Full and overflow: write 16 rows with no rd. o_full=1.
  - A 17th write on lane 3 alone is dropped and sets o_overflow=1.
  - Popping 16 rows returns the original 16 rows unaltered.
- Pop with write on full: all lanes full, rd=1 and wr=all with value 999 in the same cycle.
  - The pop returns row 0. o_full stays 1 and o_overflow stays 0.
  - The 16th subsequent pop returns 999 on every lane.
- Underflow: rd=1 with lane 5 empty and the other lanes holding data.
  - No pointer moves, o_out_valid=0, out unchanged, o_underflow=1.
- Reset mid-operation: 3 rows stored, then reset asserted for 1 cycle.
  - All outputs 0, o_valid=0.
  - One fresh row with lane i = 7*i is written and popped, and reads back exactly that row.
